// File: rtl/mf_pkg.sv
// +--------------------------------------------------------------------+
// | mf_pkg : shared constants, state encoding and counter widths for   |
// |          the matched-filter tap sequencer.   Rev 1.0               |
// +--------------------------------------------------------------------+
`default_nettype none

package mf_pkg;

   localparam int MF_ORDER  = 60;
   localparam int NUM_TAPS  = MF_ORDER + 1;
   localparam int MF_BUF_AW = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mf_state_e;

   // Bits needed to hold values 0..max_val (at least one).
   function automatic int mf_cnt_w(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) w++;
      return w;
   endfunction

   // k and fill share one width so they compare without extension; fill reaches NUM_TAPS.
   localparam int K_W    = mf_cnt_w(NUM_TAPS);
   localparam int FILL_W = mf_cnt_w(NUM_TAPS);

endpackage

`default_nettype wire

// File: rtl/mf_tap_counter.sv
// +--------------------------------------------------------------------+
// | mf_tap_counter : loadable 0..ORDER up-counter with terminal-count  |
// |                  flag; holds at ORDER.   Rev 1.0                   |
// +--------------------------------------------------------------------+
`default_nettype none

module mf_tap_counter
   import mf_pkg::*;
#(
   parameter int ORDER = MF_ORDER,
   parameter int CNT_W = K_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc = (cnt_q == CNT_W'(ORDER));

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign cnt_nxt = cnt_d;

endmodule

`default_nettype wire

// File: rtl/mf_tap_sequencer.sv
// +--------------------------------------------------------------------+
// | mf_tap_sequencer : matched-filter tap-loop sequencer (ROM/buffer   |
// |   addressing, MAC qualifiers). Optional MF_SEQ_STATUS_EN adds a    |
// |   sticky overrun flag with clr_status.   Rev 1.0                   |
// +--------------------------------------------------------------------+
`default_nettype none

module mf_tap_sequencer
   import mf_pkg::*;
#(
   parameter int ORDER  = MF_ORDER,
   parameter int ADDR_W = 32,
   parameter int BUF_AW = MF_BUF_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              buf_wr_en,
   output logic [BUF_AW-1:0] buf_wr_addr,
   output logic              buf_rd_en,
   output logic [BUF_AW-1:0] buf_rd_addr,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              mac_en,
   output logic              mac_first,
   output logic              mac_zero,
   output logic              out_valid,
   output logic              busy
`ifdef MF_SEQ_STATUS_EN
  ,output logic              overrun,
   input  logic              clr_status
`endif
);

   localparam int CNT_W = mf_cnt_w(ORDER + 1);

   generate
      if ((1 << BUF_AW) < ORDER + 1) begin : g_buf_too_small
         $error("mf_tap_sequencer: 2**BUF_AW must be >= ORDER+1");
      end
      if (ADDR_W < CNT_W) begin : g_addr_too_narrow
         $error("mf_tap_sequencer: ADDR_W too narrow for ORDER");
      end
   endgenerate

   mf_state_e         state_q, state_d;
   logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [BUF_AW-1:0] base_q, base_d;
   logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;

   logic              rom_en_q, rom_en_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              buf_rd_en_q, buf_rd_en_d;
   logic [BUF_AW-1:0] buf_rd_addr_q, buf_rd_addr_d;
   logic              mac_en_q, mac_en_d;
   logic              mac_first_q, mac_first_d;
   logic              mac_zero_q, mac_zero_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic              k_load, k_en, k_tc;
   logic [CNT_W-1:0]  k_q, k_d;
   logic              accept;

   mf_tap_counter #(
      .ORDER (ORDER),
      .CNT_W (CNT_W)
   ) u_tap_counter (
      .clk     (clk),
      .rst     (rst),
      .load    (k_load),
      .en      (k_en),
      .cnt     (k_q),
      .cnt_nxt (k_d),
      .tc      (k_tc)
   );

   assign in_ready    = (state_q == ST_IDLE);
   assign accept      = in_ready && in_valid;
   assign buf_wr_en   = accept;
   assign buf_wr_addr = wr_ptr_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      base_d     = base_q;
      fill_cnt_d = fill_cnt_q;
      k_load     = 1'b0;
      k_en       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d  = ST_RUN;
               base_d   = wr_ptr_q;
               wr_ptr_d = wr_ptr_q + 1'b1;
               k_load   = 1'b1;
               if (fill_cnt_q != CNT_W'(ORDER + 1)) begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            k_en = 1'b1;
            if (k_tc) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Address outputs follow the state/k we are entering so they are valid from the first RUN cycle.
      rom_en_d      = (state_d == ST_RUN);
      rom_addr_d    = rom_en_d ? ADDR_W'(k_d) : '0;
      buf_rd_en_d   = rom_en_d;
      buf_rd_addr_d = rom_en_d ? (base_d - BUF_AW'(k_d)) : '0;

      // MAC qualifiers describe the address issued this cycle, landing with the read data next cycle.
      mac_en_d      = (state_q == ST_RUN);
      mac_first_d   = mac_en_d && (k_q == '0);
      mac_zero_d    = mac_en_d && (k_q >= fill_cnt_q);

      out_valid_d   = (state_d == ST_DONE);
      busy_d        = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         base_q        <= '0;
         fill_cnt_q    <= '0;
         rom_en_q      <= 1'b0;
         rom_addr_q    <= '0;
         buf_rd_en_q   <= 1'b0;
         buf_rd_addr_q <= '0;
         mac_en_q      <= 1'b0;
         mac_first_q   <= 1'b0;
         mac_zero_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         base_q        <= base_d;
         fill_cnt_q    <= fill_cnt_d;
         rom_en_q      <= rom_en_d;
         rom_addr_q    <= rom_addr_d;
         buf_rd_en_q   <= buf_rd_en_d;
         buf_rd_addr_q <= buf_rd_addr_d;
         mac_en_q      <= mac_en_d;
         mac_first_q   <= mac_first_d;
         mac_zero_q    <= mac_zero_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign rom_en      = rom_en_q;
   assign rom_addr    = rom_addr_q;
   assign buf_rd_en   = buf_rd_en_q;
   assign buf_rd_addr = buf_rd_addr_q;
   assign mac_en      = mac_en_q;
   assign mac_first   = mac_first_q;
   assign mac_zero    = mac_zero_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;

`ifdef MF_SEQ_STATUS_EN
   logic overrun_q, overrun_d;

   // A fresh drop outranks a clear issued in the same cycle.
   always_comb begin
      overrun_d = overrun_q;
      if (clr_status) overrun_d = 1'b0;
      if (in_valid && !in_ready) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mf_tap_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_mf_tap_sequencer : self-checking bench for mf_tap_sequencer.    |
// |   Rev 1.0                                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mf_tap_sequencer;

   localparam int ORDER  = 60;
   localparam int N      = ORDER + 1;
   localparam int ADDR_W = 32;
   localparam int BUF_AW = 6;
   localparam int DEPTH  = 1 << BUF_AW;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              clr_status;
   logic              in_ready, buf_wr_en, buf_rd_en, rom_en;
   logic [BUF_AW-1:0] buf_wr_addr, buf_rd_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic              mac_en, mac_first, mac_zero, out_valid, busy;
`ifdef MF_SEQ_STATUS_EN
   logic              overrun;
`endif

   mf_tap_sequencer #(.ORDER(ORDER), .ADDR_W(ADDR_W), .BUF_AW(BUF_AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .buf_wr_en   (buf_wr_en),
      .buf_wr_addr (buf_wr_addr),
      .buf_rd_en   (buf_rd_en),
      .buf_rd_addr (buf_rd_addr),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .mac_en      (mac_en),
      .mac_first   (mac_first),
      .mac_zero    (mac_zero),
      .out_valid   (out_valid),
      .busy        (busy)
`ifdef MF_SEQ_STATUS_EN
     ,.overrun     (overrun),
      .clr_status  (clr_status)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int off;
      bit in_ready, wr_en, rom_en;
      int rom_addr;
      bit rd_en;
      int rd_addr;
      bit mac_en, first, zero, out_valid, busy;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   vec_t snap;
   vec_t tv[9];

   // Reference model: phase = cycles since the sample was accepted (0 = idle).
   int m_ph, m_wr, m_base, m_fill;
   bit m_ov;

   function automatic vec_t mk(int off, bit ir, bit we, bit re, int ra, bit rde, int rda,
                               bit me, bit mf, bit mz, bit ov, bit b);
      vec_t v;
      v.off = off; v.in_ready = ir; v.wr_en = we; v.rom_en = re; v.rom_addr = ra;
      v.rd_en = rde; v.rd_addr = rda; v.mac_en = me; v.first = mf; v.zero = mz;
      v.out_valid = ov; v.busy = b;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_wr = 0; m_base = 0; m_fill = 0; m_ov = 0;
   endtask

   task automatic model_update();
      if (m_ph != 0 && in_valid) m_ov = 1;
      else if (clr_status)       m_ov = 0;
      if (m_ph == 0) begin
         if (in_valid) begin
            m_base = m_wr;
            m_wr   = (m_wr + 1) % DEPTH;
            m_fill = (m_fill + 1 > N) ? N : m_fill + 1;
            m_ph   = 1;
         end
      end else if (m_ph == N + 2) begin
         m_ph = 0;
      end else begin
         m_ph++;
      end
   endtask

   task automatic check_outputs();
      bit e_idle, e_rd, e_mac;
      e_idle = (m_ph == 0);
      e_rd   = (m_ph >= 1) && (m_ph <= N);
      e_mac  = (m_ph >= 2) && (m_ph <= N + 1);
      chk("in_ready", 32'(in_ready), 32'(e_idle));
      chk("buf_wr_en", 32'(buf_wr_en), 32'(e_idle && in_valid));
      if (e_idle && in_valid) chk("buf_wr_addr", 32'(buf_wr_addr), 32'(m_wr));
      chk("rom_en", 32'(rom_en), 32'(e_rd));
      chk("buf_rd_en", 32'(buf_rd_en), 32'(e_rd));
      if (e_rd) begin
         chk("rom_addr", rom_addr, 32'(m_ph - 1));
         chk("buf_rd_addr", 32'(buf_rd_addr), 32'((((m_base - (m_ph - 1)) % DEPTH) + DEPTH) % DEPTH));
      end
      chk("mac_en", 32'(mac_en), 32'(e_mac));
      chk("mac_first", 32'(mac_first), 32'(m_ph == 2));
      if (e_mac) chk("mac_zero", 32'(mac_zero), 32'((m_ph - 2) >= m_fill));
      chk("out_valid", 32'(out_valid), 32'(m_ph == N + 2));
      chk("busy", 32'(busy), 32'(m_ph != 0));
`ifdef MF_SEQ_STATUS_EN
      chk("overrun", 32'(overrun), 32'(m_ov));
`endif
   endtask

   task automatic check_reset_state();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_wr_addr", 32'(buf_wr_addr), 32'd0);
      chk("rst_rom_en", 32'(rom_en), 32'd0);
      chk("rst_rom_addr", rom_addr, 32'd0);
      chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
      chk("rst_mac_en", 32'(mac_en), 32'd0);
      chk("rst_mac_first", 32'(mac_first), 32'd0);
      chk("rst_mac_zero", 32'(mac_zero), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef MF_SEQ_STATUS_EN
      chk("rst_overrun", 32'(overrun), 32'd0);
`endif
   endtask

   // One clock: drive at posedge+1, sample and compare at negedge, then advance the model.
   task automatic step(input bit v, input bit c);
      in_valid   = v;
      clr_status = c;
      @(negedge clk);
      snap = mk(0, in_ready, buf_wr_en, rom_en, int'(rom_addr), buf_rd_en, int'(buf_rd_addr),
                mac_en, mac_first, mac_zero, out_valid, busy);
      check_outputs();
      model_update();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int last_acc;
      // First sample after reset: base 0, fill 1.
      tv[0] = mk( 0, 1, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0);
      tv[1] = mk( 1, 0, 0, 1,  0, 1,  0, 0, 0, 0, 0, 1);
      tv[2] = mk( 2, 0, 0, 1,  1, 1, 63, 1, 1, 0, 0, 1);
      tv[3] = mk( 3, 0, 0, 1,  2, 1, 62, 1, 0, 1, 0, 1);
      tv[4] = mk(31, 0, 0, 1, 30, 1, 34, 1, 0, 1, 0, 1);
      tv[5] = mk(61, 0, 0, 1, 60, 1,  4, 1, 0, 1, 0, 1);
      tv[6] = mk(62, 0, 0, 0,  0, 0,  0, 1, 0, 1, 0, 1);
      tv[7] = mk(63, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 1);
      tv[8] = mk(64, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);

      rst = 1'b0; in_valid = 1'b0; clr_status = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single sample at cycle 5, compared against the vector table.
      repeat (5) step(1'b0, 1'b0);
      for (int off = 0; off <= 64; off++) begin
         step(off == 0, 1'b0);
         for (int t = 0; t < 9; t++) begin
            if (tv[t].off == off) begin
               chk("tv_in_ready", 32'(snap.in_ready), 32'(tv[t].in_ready));
               chk("tv_wr_en", 32'(snap.wr_en), 32'(tv[t].wr_en));
               chk("tv_rom_en", 32'(snap.rom_en), 32'(tv[t].rom_en));
               if (tv[t].rom_en) chk("tv_rom_addr", 32'(snap.rom_addr), 32'(tv[t].rom_addr));
               chk("tv_rd_en", 32'(snap.rd_en), 32'(tv[t].rd_en));
               if (tv[t].rd_en) chk("tv_rd_addr", 32'(snap.rd_addr), 32'(tv[t].rd_addr));
               chk("tv_mac_en", 32'(snap.mac_en), 32'(tv[t].mac_en));
               chk("tv_mac_first", 32'(snap.first), 32'(tv[t].first));
               if (tv[t].mac_en) chk("tv_mac_zero", 32'(snap.zero), 32'(tv[t].zero));
               chk("tv_out_valid", 32'(snap.out_valid), 32'(tv[t].out_valid));
               chk("tv_busy", 32'(snap.busy), 32'(tv[t].busy));
            end
         end
      end

      // in_valid held high: 70 back-to-back samples, one accept every N+3 cycles.
      last_acc = -1;
      for (int i = 0; i < 70 * (N + 3); i++) begin
         step(1'b1, 1'b0);
         if (snap.wr_en) begin
            if (last_acc >= 0) chk("accept_gap", 32'(i - last_acc), 32'(N + 3));
            last_acc = i;
         end
      end
      repeat (3) step(1'b0, 1'b1);

      // Randomised traffic with occasional status clears.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end

      // Asynchronous reset in the middle of a sweep.
      for (int i = 0; i < 2 * N && m_ph != 0; i++) step(1'b0, 1'b0);
      chk("idle_before_abort", 32'(m_ph), 32'd0);
      step(1'b1, 1'b0);
      repeat (30) step(1'b0, 1'b0);
      chk("pre_abort_rom_addr", rom_addr, 32'd30);
      #2 rst = 1'b0;
      #1;
      check_reset_state();
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (2) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (N + 5) step(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mf_tap_sequencer.md
Name: mf_tap_sequencer

Overview:
- Sequences the matched-filter tap loop. For each accepted input sample it sweeps the coefficient ROM address 0..ORDER and the sample history ring-buffer read address in lockstep.
- Issues the MAC enable, first and zero qualifiers aligned to the 1-cycle ROM/buffer read latency, then pulses out_valid when the dot product is complete.
- Sits between the sample input stream, the coefficient ROM(s), the sample buffer RAM and the MAC datapath.

Parameters:
- ORDER, 60, filter order; taps = ORDER+1; valid ROM addresses 0..ORDER.
- ADDR_W, 32, width of rom_addr; matches the ROM address port.
- BUF_AW, 6, sample ring-buffer address width; 2**BUF_AW >= ORDER+1 (elaboration check).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  new input sample present on the datapath this cycle.
- in_ready  out  1  sequencer idle and able to accept a sample.
- buf_wr_en  out  1  write the current sample into the ring buffer.
- buf_wr_addr  out  BUF_AW  ring-buffer write address.
- buf_rd_en  out  1  ring-buffer read enable.
- buf_rd_addr  out  BUF_AW  ring-buffer read address.
- rom_en  out  1  coefficient ROM enable.
- rom_addr  out  ADDR_W  coefficient index k.
- mac_en  out  1  MAC accumulates this cycle (operands valid).
- mac_first  out  1  with mac_en: load the product instead of accumulating.
- mac_zero  out  1  with mac_en: force the sample operand to 0 (history not yet filled).
- out_valid  out  1  one-cycle pulse: MAC result is final.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, wr_ptr=0, base=0, k=0, fill_cnt=0, every output 0 except in_ready=1. A reset mid-sweep aborts with no out_valid.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered except in_ready and buf_wr_*, which are combinational from state and in_valid.
- IDLE:
  - in_ready=1.
  - If in_valid: buf_wr_en=1 and buf_wr_addr=wr_ptr in the same cycle.
  - Next state: base<=wr_ptr, wr_ptr<=wr_ptr+1 (mod 2**BUF_AW), fill_cnt<=min(fill_cnt+1, ORDER+1), k<=0, go to RUN.
- RUN (ORDER+1 cycles):
  - rom_en=1, rom_addr=k zero-extended.
  - buf_rd_en=1, buf_rd_addr=(base-k) mod 2**BUF_AW.
  - k increments each cycle. On k==ORDER go to DRAIN.
- Operand alignment: mac_en, mac_first and mac_zero are delayed 1 cycle from the address they qualify.
  - mac_en is high for exactly ORDER+1 consecutive cycles, starting the cycle after RUN entry.
  - mac_first=1 only on the beat for k=0.
  - mac_zero=1 on beats where k >= fill_cnt, i.e. history older than the number of samples received since reset.
- DRAIN: 1 cycle. Last MAC beat (k=ORDER) occurs here. rom_en=0, buf_rd_en=0.
- DONE: out_valid=1 for 1 cycle, then return to IDLE.
- Latency and throughput: accept at cycle T; rom_addr=0 at T+1; rom_addr=ORDER at T+ORDER+1; last mac_en at T+ORDER+2; out_valid at T+ORDER+3. in_ready is next high at T+ORDER+4.
- in_valid while in_ready=0 is ignored: no write, no pointer change.
- Addresses above ORDER are never issued. wr_ptr and rd addresses wrap modulo 2**BUF_AW. fill_cnt saturates at ORDER+1.

Optional Feature:
- Macro: MF_SEQ_STATUS_EN.
- With the macro defined, two additional ports:
  - overrun out 1: sticky. Sets when in_valid=1 while in_ready=0.
  - clr_status in 1: synchronous clear of overrun. If clr_status and a new overrun event occur in the same cycle, set wins.
  - overrun resets to 0.
- Without the macro, these ports and their logic are absent. Dropped samples are silent.

Decomposition:
- Shared package mf_pkg holds:
  - ORDER default and NUM_TAPS=ORDER+1;
  - BUF_AW default;
  - state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - widths for the k and fill counters.
- One sub-module, mf_tap_counter: a loadable 0..ORDER up-counter with a terminal-count flag. It drives k and the RUN->DRAIN transition.

Test Plan:
- Reset, then a single in_valid at cycle 5 -> buf_wr_addr=0 at cycle 5. rom_addr 0..60 on cycles 6..66. mac_en on 7..67, mac_first only at 7. out_valid at 68 only. in_ready high again at 69.
- First sample after reset -> mac_zero=0 only for k=0 and =1 for k=1..60. The 3rd sample has mac_zero=0 for k=0..2.
- 70 back-to-back samples -> after sample 61, mac_zero is never set. Sample 65 (wr addr 0, wrap) reads buf_rd_addr sequence 0,63,62,...
- Sample with base=2 -> buf_rd_addr sequence 2,1,0,63,...,6 across the 61 beats.
- in_valid held high continuously -> exactly one accept every 64 cycles, no buf_wr_en outside IDLE. With MF_SEQ_STATUS_EN, overrun=1 after the first ignored cycle; clr_status clears it.
- rst low at rom_addr=30 -> all outputs 0 asynchronously, no out_valid, in_ready=1. The next sample sees fill_cnt=1 behaviour.
